// File: rtl/fir_stream_src_pkg.sv
// Shared definitions for the FIR stream source: state encoding and read stride.
package fir_stream_src_pkg;

    // Transfer controller states (legacy-compatible plain constants).
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Each sample occupies one 32-bit BRAM word, so addresses advance by 4 bytes.
    localparam int BYTE_STRIDE = 4;

    // State entered from IDLE/DONE when a start is accepted.
    function automatic logic [1:0] start_target(input logic [31:0] len);
        return (len == 32'd0) ? S_DONE : S_RUN;
    endfunction

endpackage

// File: rtl/fir_stream_src_if.sv
// AXI-Stream bundle between the sample source and the FIR core.
interface fir_stream_src_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   ss_tready;

    modport master (output ss_tvalid, ss_tdata, ss_tlast, input ss_tready);
    modport slave  (input ss_tvalid, ss_tdata, ss_tlast, output ss_tready);
endinterface

// File: rtl/fir_skid_buf.sv
// Two-entry data+last buffer with valid/ready on both sides.
module fir_skid_buf #(
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [pDATA_WIDTH-1:0] i_data,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [pDATA_WIDTH-1:0] o_data,
    output logic                   o_last,
    output logic [1:0]             o_count
);
    logic [pDATA_WIDTH-1:0] r_data [2];
    logic [1:0]             r_last;
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;
    logic                   w_push;
    logic                   w_pop;

    // A full buffer still accepts a write in the cycle its head drains.
    assign o_ready = (r_count != 2'd2) || i_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_data[r_rd_ptr];
    assign o_last  = o_valid && r_last[r_rd_ptr];
    assign o_count = r_count;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    // Circular two-slot storage with occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data slots are reset too because the stream data output must read 0 after reset.
            for (int i = 0; i < 2; i++) r_data[i] <= '0;
            r_last   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= i_data;
                r_last[r_wr_ptr] <= i_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            // NOTE: non-blocking updates keep every register reading its pre-edge value inside this block.
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/fir_stream_src.sv
// Streams data_length samples from a synchronous BRAM to the FIR over AXI-Stream.
module fir_stream_src
    import fir_stream_src_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   start,
    input  logic [pADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]            data_length,
    output logic                   busy,
    output logic                   done,
    output logic                   src_EN,
    output logic [3:0]             src_WE,
    output logic [pADDR_WIDTH-1:0] src_A,
    input  logic [pDATA_WIDTH-1:0] src_Do,
    fir_stream_src_if.master       ss
);
    logic [1:0]             r_state;
    logic [31:0]            r_len;
    logic [31:0]            r_rd_idx;
    logic [pADDR_WIDTH-1:0] r_addr;
    logic                   r_pending;    // read issued last cycle, data on src_Do now
    logic                   r_pend_last;  // that read was the final sample

    logic                   w_tvalid;
    logic [pDATA_WIDTH-1:0] w_tdata;
    logic                   w_tlast;
    logic                   w_skid_ready;
    logic [1:0]             w_buf_count;
    logic                   w_pop;
    logic [2:0]             w_occ_next;
    logic                   w_src_en;
    logic                   w_rd_is_last;

    assign w_pop        = w_tvalid && ss.ss_tready;
    // Slots held after this edge: in-flight plus buffered, minus the beat leaving now.
    assign w_occ_next   = 3'(r_pending) + 3'(w_buf_count) - 3'(w_pop);
    assign w_src_en     = (r_state == S_RUN) && (r_rd_idx != r_len) && (w_occ_next < 3'd2);
    assign w_rd_is_last = (r_rd_idx == r_len - 32'd1);

    assign src_EN = w_src_en;
    assign src_WE = 4'b0000;
    assign src_A  = r_addr;
    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);

    assign ss.ss_tvalid = w_tvalid;
    assign ss.ss_tdata  = w_tdata;
    assign ss.ss_tlast  = w_tlast;

    fir_skid_buf #(.pDATA_WIDTH(pDATA_WIDTH)) u_skid (
        .clk     (axis_clk),
        .rst     (axis_rst),
        .i_valid (r_pending),
        .o_ready (w_skid_ready),
        .i_data  (src_Do),
        .i_last  (r_pend_last),
        .o_valid (w_tvalid),
        .i_ready (ss.ss_tready),
        .o_data  (w_tdata),
        .o_last  (w_tlast),
        .o_count (w_buf_count)
    );

    // Credit accounting must never let returning read data meet a full buffer.
    assert property (@(posedge axis_clk) disable iff (axis_rst) r_pending |-> w_skid_ready);

    // Transfer control: start acceptance, read issue, and completion on the last beat.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_state     <= S_IDLE;
            r_len       <= 32'd0;
            r_rd_idx    <= 32'd0;
            r_addr      <= '0;
            r_pending   <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_pending   <= w_src_en;
            r_pend_last <= w_src_en && w_rd_is_last;
            case (r_state)
                S_RUN: begin
                    if (w_src_en) begin
                        r_rd_idx <= r_rd_idx + 32'd1;
                        r_addr   <= r_addr + pADDR_WIDTH'(BYTE_STRIDE);
                    end
                    if (w_pop && w_tlast) r_state <= S_DONE;
                end
                default: begin
                    if (start) begin
                        r_state  <= start_target(data_length);
                        r_len    <= data_length;
                        r_rd_idx <= 32'd0;
                        r_addr   <= base_addr;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_stream_src.sv
// Self-checking bench: BRAM model, transfer-level reference model, per-cycle compare.
module tb_fir_stream_src;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          axis_clk = 1'b0;
    logic          axis_rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [31:0]   data_length;
    logic          busy, done, src_EN;
    logic [3:0]    src_WE;
    logic [AW-1:0] src_A;
    logic [DW-1:0] src_Do;

    fir_stream_src_if #(.pDATA_WIDTH(DW)) ss ();

    fir_stream_src #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
        .axis_clk    (axis_clk),
        .axis_rst    (axis_rst),
        .start       (start),
        .base_addr   (base_addr),
        .data_length (data_length),
        .busy        (busy),
        .done        (done),
        .src_EN      (src_EN),
        .src_WE      (src_WE),
        .src_A       (src_A),
        .src_Do      (src_Do),
        .ss          (ss)
    );

    always #5 axis_clk = ~axis_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge axis_clk) cyc <= cyc + 1;

    // Source BRAM: word addressed by the byte address, one-cycle read latency.
    logic [DW-1:0] mem [1024];
    always @(posedge axis_clk) if (src_EN) src_Do <= mem[src_A[AW-1:2]];

    // Reference model state: what the current transfer must still produce.
    logic          m_busy = 1'b0, m_done = 1'b0;
    logic [DW-1:0] q_data [$];
    logic          q_last [$];
    logic [AW-1:0] q_addr [$];
    int            acc_cyc = 0, n_out = 0, done_rises = 0;
    bit            seen_first_read = 0, seen_first_beat = 0, ready_run = 0;
    logic          prev_stall = 1'b0, prev_last = 1'b0, prev_rst = 1'b1, prev_done = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit            mon_en = 0;
    int            ready_mode = 0;

    // Observation logs for the directed tests.
    logic [DW-1:0] obs_data [$];
    logic          obs_last [$];
    int            obs_cyc  [$];
    logic [AW-1:0] obs_addr [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model, then model update.
    task automatic monitor_cycle();
        logic          hs, was_busy, lst;
        logic [AW-1:0] a;
        hs       = ss.ss_tvalid && ss.ss_tready;
        was_busy = m_busy;
        check("busy", busy, m_busy);
        check("done", done, m_done);
        if (done && !prev_done) done_rises++;
        prev_done = done;
        if (src_EN) begin
            obs_addr.push_back(src_A);
            n_out++;
            check("read_expected", q_addr.size() != 0, 1);
            if (q_addr.size() != 0) begin
                if (!seen_first_read) begin
                    check("first_read_cycle", cyc, acc_cyc + 1);
                    seen_first_read = 1;
                end
                check("src_A", src_A, q_addr.pop_front());
            end
        end
        if (seen_first_beat && ready_run && q_data.size() != 0)
            check("no_bubble", ss.ss_tvalid, 1);
        if (ss.ss_tvalid) begin
            check("beat_expected", q_data.size() != 0, 1);
            if (q_data.size() != 0) begin
                check("tdata", ss.ss_tdata, q_data[0]);
                check("tlast", ss.ss_tlast, q_last[0]);
            end
            if (!seen_first_beat) begin
                // start sampled at edge acc_cyc+1; data captured two edges later
                check("first_beat_cycle", cyc, acc_cyc + 3);
                seen_first_beat = 1;
            end
        end
        if (seen_first_beat) ready_run = ready_run && ss.ss_tready;
        if (prev_stall && !prev_rst) begin
            check("hold_valid", ss.ss_tvalid, 1);
            check("hold_data", ss.ss_tdata, prev_data);
            check("hold_last", ss.ss_tlast, prev_last);
        end
        if (hs) begin
            obs_data.push_back(ss.ss_tdata);
            obs_last.push_back(ss.ss_tlast);
            obs_cyc.push_back(cyc);
            n_out--;
            if (q_data.size() != 0) begin
                lst = q_last.pop_front();
                void'(q_data.pop_front());
                if (lst) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        check("slots", n_out <= 2, 1);
        if (start && !was_busy && !axis_rst) begin
            q_data.delete(); q_last.delete(); q_addr.delete();
            for (int i = 0; i < int'(data_length); i++) begin
                a = base_addr + AW'(4 * i);
                q_addr.push_back(a);
                q_data.push_back(mem[a >> 2]);
                q_last.push_back(i == int'(data_length) - 1);
            end
            acc_cyc         = cyc;
            seen_first_read = 0;
            seen_first_beat = 0;
            ready_run       = 1;
            m_busy          = (data_length != 0);
            m_done          = (data_length == 0);
        end
        if (axis_rst) begin
            q_data.delete(); q_last.delete(); q_addr.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            n_out  = 0;
            seen_first_beat = 0;
            ready_run = 0;
        end
        prev_stall = ss.ss_tvalid && !ss.ss_tready;
        prev_data  = ss.ss_tdata;
        prev_last  = ss.ss_tlast;
        prev_rst   = axis_rst;
    endtask

    initial forever begin
        @(negedge axis_clk);
        if (mon_en) monitor_cycle();
    end

    // tready pattern: 0 always high, 1 toggle, 2 random (mostly high), 3 held low.
    initial forever begin
        @(posedge axis_clk);
        #2;
        case (ready_mode)
            0:       ss.ss_tready = 1'b1;
            1:       ss.ss_tready = ~ss.ss_tready;
            2:       ss.ss_tready = ($urandom_range(0, 3) != 0);
            default: ss.ss_tready = 1'b0;
        endcase
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge axis_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [31:0] len);
        start       = 1'b1;
        base_addr   = b;
        data_length = len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_finish(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("finish_in_budget", busy, 0);
        tick(2);
    endtask

    task automatic do_reset();
        axis_rst = 1'b1;
        tick(2);
        axis_rst = 1'b0;
        tick();
    endtask

    task automatic clear_logs();
        obs_data.delete(); obs_last.delete(); obs_cyc.delete(); obs_addr.delete();
        done_rises = 0;
    endtask

    initial begin
        logic [DW-1:0] lit [4];
        logic [3:0]    pat;
        int            n;
        logic [31:0]   len;

        axis_rst = 1'b1; start = 1'b0; base_addr = '0; data_length = '0;
        ss.ss_tready = 1'b1; src_Do = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'd5; mem[1] = 32'd6; mem[2] = 32'd7; mem[3] = 32'd8;
        tick(3);
        mon_en = 1;

        // Reset state
        check("rst_tvalid", ss.ss_tvalid, 0);
        check("rst_tdata", ss.ss_tdata, 0);
        check("rst_tlast", ss.ss_tlast, 0);
        check("rst_src_EN", src_EN, 0);
        check("rst_src_A", src_A, 0);
        check("rst_src_WE", src_WE, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        axis_rst = 1'b0;
        tick(2);

        // Four samples with tready high: 5,6,7,8 back to back, tlast on the last
        clear_logs();
        ready_mode = 0;
        pulse_start(12'h000, 32'd4);
        wait_finish(50);
        lit = '{32'd5, 32'd6, 32'd7, 32'd8};
        check("t1_count", obs_data.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t1_data%0d", i), obs_data[i], lit[i]);
        pat = {obs_last[3], obs_last[2], obs_last[1], obs_last[0]};
        check("t1_last_pattern", pat, 4'b1000);
        check("t1_consecutive", obs_cyc[3] - obs_cyc[0], 3);
        check("t1_done", done, 1);

        // Six samples under a toggling tready
        clear_logs();
        ready_mode = 1;
        pulse_start(12'h100, 32'd6);
        wait_finish(80);
        check("t2_count", obs_data.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("t2_data%0d", i), obs_data[i], mem[64 + i]);

        // Zero-length transfer: done next cycle, no reads, no beats
        ready_mode = 0;
        do_reset();
        clear_logs();
        pulse_start(12'h020, 32'd0);
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        tick(4);
        check("t3_reads", obs_addr.size(), 0);
        check("t3_beats", obs_data.size(), 0);

        // Address wrap at the top of the BRAM
        clear_logs();
        pulse_start(12'hFF8, 32'd4);
        wait_finish(50);
        check("t4_reads", obs_addr.size(), 4);
        check("t4_addr0", obs_addr[0], 12'hFF8);
        check("t4_addr1", obs_addr[1], 12'hFFC);
        check("t4_addr2", obs_addr[2], 12'h000);
        check("t4_addr3", obs_addr[3], 12'h004);
        pat = {obs_last[3], obs_last[2], obs_last[1], obs_last[0]};
        check("t4_last_pattern", pat, 4'b1000);

        // A second start while running is ignored
        clear_logs();
        pulse_start(12'h200, 32'd3);
        start = 1'b1; base_addr = 12'h000; data_length = 32'd7;
        tick();
        start = 1'b0;
        wait_finish(50);
        tick(3);
        check("t5_beats", obs_data.size(), 3);
        check("t5_done_once", done_rises, 1);

        // Reset after the second of five beats
        clear_logs();
        pulse_start(12'h000, 32'd5);
        n = 0;
        while (obs_data.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        check("t6_reached_beat2", obs_data.size(), 2);
        axis_rst   = 1'b1;
        ready_mode = 3;
        tick();
        check("t6_tvalid_after_rst", ss.ss_tvalid, 0);
        check("t6_src_EN_after_rst", src_EN, 0);
        axis_rst   = 1'b0;
        ready_mode = 0;
        tick(5);
        check("t6_no_more_beats", obs_data.size(), 2);
        clear_logs();
        pulse_start(12'h000, 32'd2);
        wait_finish(50);
        check("t6_restart_count", obs_data.size(), 2);
        check("t6_restart_d0", obs_data[0], 32'd5);
        check("t6_restart_d1", obs_data[1], 32'd6);

        // Randomized transfers with random back-pressure and stray starts
        ready_mode = 2;
        for (int t = 0; t < 25; t++) begin
            len = 32'($urandom_range(0, 12));
            pulse_start(AW'($urandom_range(0, 4095)), len);
            if (len > 2 && $urandom_range(0, 1) == 1) begin
                tick($urandom_range(0, 3));
                start = 1'b1; data_length = 32'($urandom_range(1, 9));
                tick();
                start = 1'b0;
            end
            wait_finish(300);
            tick($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
